// File: rtl/button_cmd_scheduler.sv
// button_cmd_scheduler: shared-tick debouncer for N buttons feeding a round-robin
// valid/ready command issuer toward the execution unit.
module button_cmd_scheduler #(
  parameter int N_BTN    = 4,
  parameter int TICK_DIV = 200000,
  parameter int SAMPLES  = 4,
  parameter int ID_W     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  output logic [N_BTN-1:0] btn_level,
  output logic             overrun,
  output logic             tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0]      cnt;
  logic [N_BTN-1:0]   sync1, s, level_d, pending, rise, issue;
  logic [SAMPLES-1:0] hist [N_BTN];
  logic [SAMPLES-1:0] nh [N_BTN];
  logic [ID_W-1:0]    ptr, winner, ptr_next;
  logic               free, load;
  assign tick     = cnt == CW'(TICK_DIV - 1);
  assign rise     = btn_level & ~level_d;
  assign free     = ~cmd_valid | cmd_ready;
  assign load     = free & (|pending);
  assign issue    = load ? N_BTN'(1) << winner : '0;
  assign ptr_next = winner == ID_W'(N_BTN - 1) ? '0 : winner + 1'b1;
  always_comb begin
    for (int i = 0; i < N_BTN; i++) nh[i] = {hist[i][SAMPLES-2:0], s[i]};
  end
  // Scan downward so the lowest offset from ptr is assigned last and wins.
  always_comb begin
    winner = ptr;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      automatic int j = (int'(ptr) + k) % N_BTN;
      if (pending[j]) winner = ID_W'(j);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      sync1     <= '0;
      s         <= '0;
      level_d   <= '0;
      btn_level <= '0;
      pending   <= '0;
      overrun   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
      ptr       <= '0;
      for (int i = 0; i < N_BTN; i++) hist[i] <= '0;
    end else begin
      cnt     <= tick ? '0 : cnt + 1'b1;
      sync1   <= btn_in;
      s       <= sync1;
      level_d <= btn_level;
      if (tick)
        for (int i = 0; i < N_BTN; i++) begin
          hist[i]      <= nh[i];
          btn_level[i] <= &nh[i] ? 1'b1 : (|nh[i] ? btn_level[i] : 1'b0);
        end
      pending <= (pending & ~issue) | rise;
      overrun <= |(rise & pending & ~issue);
      if (free) cmd_valid <= |pending;
      if (load) begin
        cmd_id <= winner;
        ptr    <= ptr_next;
      end
    end
  end
endmodule

// File: tb/tb_button_cmd_scheduler.sv
// tb_button_cmd_scheduler: directed stimulus with an expected-command queue
// popped on each handshake.
module tb_button_cmd_scheduler;
  localparam int N = 4, TD = 4, SM = 3, IW = 2;
  logic          clk = 0, reset = 0, cmd_ready = 0;
  logic [N-1:0]  btn_in = '0;
  logic          cmd_valid, overrun, tick;
  logic [IW-1:0] cmd_id;
  logic [N-1:0]  btn_level;
  int checks = 0, failures = 0, cyc = 0, ovr_cnt = 0, exp_id, t0, t1, o0;
  int q[$];

  button_cmd_scheduler #(.N_BTN(N), .TICK_DIV(TD), .SAMPLES(SM), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .btn_level(btn_level),
    .overrun(overrun), .tick(tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (overrun) ovr_cnt++;
      if (cmd_valid && cmd_ready) begin
        if (q.size() == 0) chk("unexpected_cmd", {31'b0, cmd_valid}, 0);
        else begin
          exp_id = q.pop_front();
          chk("cmd_id", {30'b0, cmd_id}, exp_id);
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick;
    int b = 0;
    do begin @(negedge clk); b++; end while (!tick && b < 100);
    if (!tick) chk("tick_timeout", {31'b0, tick}, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(output int at);
    int b = 0;
    while (!cmd_valid && b < 300) begin @(posedge clk); #1; b++; end
    if (!cmd_valid) chk("valid_timeout", {31'b0, cmd_valid}, 1);
    at = cyc;
  endtask

  task automatic drain;
    int b = 0;
    while (q.size() != 0 && b < 500) begin @(posedge clk); #1; b++; end
    chk("drain", q.size(), 0);
  endtask

  task automatic settle;
    btn_in = '0;
    repeat (6) wait_tick;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset defaults with buttons held
    reset = 0; btn_in = 4'hF; cmd_ready = 1;
    cycles(3);
    chk("rst_valid", {31'b0, cmd_valid}, 0);
    chk("rst_id", {30'b0, cmd_id}, 0);
    chk("rst_level", {28'b0, btn_level}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    chk("rst_tick", {31'b0, tick}, 0);
    @(negedge clk); reset = 1;
    q.push_back(0); q.push_back(1); q.push_back(2); q.push_back(3);
    wait_tick; wait_tick;
    chk("level_pre", {28'b0, btn_level}, 0);
    wait_tick;
    chk("level_3rd_tick", {28'b0, btn_level}, 4'hF);
    cycles(2);
    chk("first_latency", {31'b0, cmd_valid}, 1);
    chk("first_id", {30'b0, cmd_id}, 0);
    cycles(1);
    chk("b2b_valid", {31'b0, cmd_valid}, 1);
    drain;
    cycles(1);
    chk("idle_after_burst", {31'b0, cmd_valid}, 0);
    settle;

    // bounce rejection on button 1
    cmd_ready = 1;
    for (int k = 0; k < 8; k++) begin
      btn_in[1] = ~btn_in[1];
      repeat (5) @(posedge clk);
      #1;
    end
    chk("bounce_level", {28'b0, btn_level}, 0);
    btn_in[1] = 1; q.push_back(1);
    begin
      int b = 0;
      while (!btn_level[1] && b < 200) begin @(posedge clk); #1; b++; end
    end
    chk("bounce_qualified", {31'b0, btn_level[1]}, 1);
    t0 = cyc;
    wait_valid(t1);
    chk("bounce_latency", t1 - t0, 2);
    chk("bounce_id", {30'b0, cmd_id}, 1);
    drain;
    settle;

    // back-pressure holds command stable
    cmd_ready = 0; btn_in = 4'b0100; q.push_back(2);
    wait_valid(t1);
    for (int k = 0; k < 20; k++) begin
      chk("bp_valid", {31'b0, cmd_valid}, 1);
      chk("bp_id", {30'b0, cmd_id}, 2);
      cycles(1);
    end
    cmd_ready = 1;
    cycles(1);
    chk("bp_release", {31'b0, cmd_valid}, 0);
    chk("bp_drained", q.size(), 0);
    settle;

    // round robin from pointer 1 with pending 1011
    cmd_ready = 0; btn_in = 4'b0001; q.push_back(0);
    wait_valid(t1);
    settle;
    btn_in = 4'b1011;
    q.push_back(1); q.push_back(3); q.push_back(0);
    repeat (5) wait_tick;
    chk("rr_pending", {28'b0, dut.pending}, 4'b1011);
    chk("rr_inflight", {30'b0, cmd_id}, 0);
    cmd_ready = 1;
    drain;
    chk("rr_ptr", {30'b0, dut.ptr}, 1);
    settle;

    // overrun on second rise of button 3 while its press is still pending
    cmd_ready = 0; btn_in = 4'b0001; q.push_back(0);
    wait_valid(t1);
    o0 = ovr_cnt;
    btn_in = 4'b1001; q.push_back(3);
    repeat (5) wait_tick;
    chk("ovr_first_press", ovr_cnt - o0, 0);
    chk("ovr_pending", {28'b0, dut.pending}, 4'b1000);
    btn_in = 4'b0001;
    repeat (6) wait_tick;
    btn_in = 4'b1001;
    repeat (5) wait_tick;
    chk("ovr_pulse", ovr_cnt - o0, 1);
    cmd_ready = 1;
    drain;
    cycles(3);
    chk("ovr_idle", {31'b0, cmd_valid}, 0);
    settle;

    // asynchronous reset mid-operation
    cmd_ready = 0; btn_in = 4'b0001;
    wait_valid(t1);
    btn_in = 4'b0111;
    repeat (5) wait_tick;
    chk("mid_pending", {28'b0, dut.pending}, 4'b0110);
    @(posedge clk); #2;
    reset = 0; #1;
    chk("mid_valid", {31'b0, cmd_valid}, 0);
    chk("mid_pending_clr", {28'b0, dut.pending}, 0);
    chk("mid_level", {28'b0, btn_level}, 0);
    btn_in = '0; cmd_ready = 1;
    @(negedge clk); reset = 1;
    repeat (8) wait_tick;
    chk("post_reset_quiet", {31'b0, cmd_valid}, 0);
    btn_in = 4'b0100; q.push_back(2);
    drain;
    settle;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/button_cmd_scheduler.md
Name: button_cmd_scheduler

Overview:
- Debounces N raw pushbutton inputs using one shared sample-tick generator.
- Converts each debounced press into a pending command request.
- Issues those commands one at a time to the CPU execution unit over a valid/ready handshake, with round-robin arbitration.
- Replaces per-button debounce instances with a single shared, sequenced resource sitting between the board buttons and the execution unit's command input.

Parameters:
- N_BTN, 4: number of button inputs (2..8).
- TICK_DIV, 200000: clk cycles per sample tick (100 MHz -> 500 Hz); must be >= 2.
- SAMPLES, 4: consecutive identical samples required to change a debounced level (2..8).
- ID_W, 2: width of cmd_id; must satisfy 2^ID_W >= N_BTN.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- btn_in, input, N_BTN: raw asynchronous button levels; 1 = pressed.
- cmd_ready, input, 1: execution unit accepts a command this cycle.
- cmd_valid, output, 1: command present on cmd_id.
- cmd_id, output, ID_W: index of the button whose press is being issued.
- btn_level, output, N_BTN: debounced button levels.
- overrun, output, 1: one-cycle pulse when a press is dropped.
- tick, output, 1: one-cycle sample strobe, for debug and bench sync.

Behaviour:
- Reset (reset=0, asynchronous): tick counter=0, synchronisers=0, every history register=0, btn_level=0, pending=0, cmd_valid=0, cmd_id=0, RR pointer=0, overrun=0, tick=0.
  - Reset applied mid-operation discards all pending and in-flight commands; no cmd_valid is asserted until a new press qualifies.
  - A button held through reset release is debounced from history=0 and yields one press once SAMPLES ticks have sampled it high.
- Tick generator: counter runs 0..TICK_DIV-1 and wraps. tick=1 for exactly the one cycle where counter==TICK_DIV-1.
- Synchroniser: two-flop synchroniser per bit; the second stage is the sample value s[i].
- Debounce, per button, on tick cycles only: history[i] <= {history[i][SAMPLES-2:0], s[i]}.
  - On that same edge, btn_level[i] <= 1 if the new history is all ones, <= 0 if it is all zeros; otherwise btn_level holds.
  - Between ticks, history and btn_level are unchanged.
- Edge detect: rise[i] = btn_level[i] & ~btn_level_d[i], where btn_level_d is a one-cycle delayed copy of btn_level. Falling edges generate nothing.
- Pending: pending[i] sets on the edge after rise[i].
  - If rise[i] occurs while pending[i]=1, overrun pulses for one cycle and pending stays 1 (the press is dropped).
  - Issue and set on the same bit in the same cycle: set wins (pending[i] remains 1, no overrun).
- Output register load condition: load = (~cmd_valid | cmd_ready) & (pending != 0).
  - On load: cmd_id <= winner, cmd_valid <= 1, pending[winner] <= 0, RR pointer <= winner+1 (mod N_BTN).
  - If (~cmd_valid | cmd_ready) and pending==0: cmd_valid <= 0.
  - While cmd_valid=1 and cmd_ready=0, cmd_id and cmd_valid hold stable.
  - Back-to-back issue is allowed: a handshake and a new load can happen on the same edge.
- Arbitration: winner is the first set pending bit searching upward from the RR pointer, wrapping past N_BTN-1 to 0. Winner selection is purely combinational from registered pending and pointer.
- Latency, from a stable press with the output free:
  - btn_level rises on the tick edge that shifts in the SAMPLES-th consecutive 1.
  - pending sets 1 cycle later.
  - cmd_valid rises 1 cycle after that.
  - Total: tick edge + 2 cycles.
- Glitches shorter than SAMPLES ticks never change btn_level.

Test Plan:
- Reset defaults (TICK_DIV=4, SAMPLES=3): hold reset=0 with btn_in=4'b1111 -> all outputs 0. Release reset, keep buttons held -> each btn_level goes high on the 3rd tick after release, and cmd_ids 0,1,2,3 are issued in order with cmd_ready=1, each cmd_valid for 1 cycle back-to-back.
- Bounce rejection: btn_in[1] toggles every 5 clks for 40 clks, then is held high -> no cmd_valid during toggling; exactly one command with cmd_id=1, arriving 2 cycles after the qualifying tick edge.
- Back-pressure: press btn 2, hold cmd_ready=0 for 20 cycles -> cmd_valid=1 with cmd_id=2 held stable throughout. Raise cmd_ready -> handshake completes, cmd_valid=0 next cycle.
- Round-robin fairness: pointer=1, pending=4'b1011, cmd_ready=1 -> issue order 1,3,0. Pointer ends at 1.
- Overrun: stall with cmd_ready=0 while btn 0 is issued; press, release and re-press btn 3 twice (full debounce each time) -> one overrun pulse on the second rise; exactly one cmd_id=3 is issued after cmd_ready returns.
- Reset mid-operation: with cmd_valid=1 and pending=4'b0110, assert reset asynchronously between clock edges -> cmd_valid, pending and btn_level all go to 0 immediately; no commands after release until new presses qualify.
